// File: rtl/ts_pattern_gen.sv
// MPEG transport-stream test pattern generator: round-robin PIDs, per-PID continuity
// counters, selectable payload, optional RS parity filler and inter-packet gap.
module ts_pattern_gen #(
    parameter int PKT_LEN = 188,
    parameter int N_PID   = 4,
    parameter int GAP     = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [12:0] PID_BASE,
    input  logic [1:0]  MODE,
    output logic [7:0]  DATA,
    output logic        D_CLK,
    output logic        D_VALID,
    output logic        P_SYNC,
    output logic [15:0] PKT_CNT
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_PAR, S_GAP} state_t;

    localparam logic [7:0] LAST_IDX  = 8'(PKT_LEN - 1);
    localparam logic [7:0] GAP_LAST  = (GAP == 0) ? 8'd0 : 8'(GAP - 1);
    localparam logic [2:0] SLOT_LAST = 3'(N_PID - 1);

    state_t      state, state_nxt, after_pkt;
    logic [7:0]  idx, idx_nxt;
    logic [7:0]  gap_cnt, gap_cnt_nxt;
    logic [2:0]  slot;
    logic [3:0]  cc [8];
    logic [12:0] base_lat;
    logic [1:0]  mode_lat;
    logic [14:0] lfsr;
    logic [12:0] pid;
    logic [7:0]  data_nxt;
    logic        valid_nxt, sync_nxt, lfsr_step;
    logic        pkt_end, done_p1;

    assign D_CLK   = CLK;
    assign pid     = base_lat + {10'd0, slot};
    assign pkt_end = ((state == S_PAY) || (state == S_PAR)) && (idx == LAST_IDX);

    always_comb begin
        after_pkt = EN ? S_HDR : S_IDLE;
        if (GAP != 0) after_pkt = S_GAP;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= S_IDLE;
            idx     <= 8'd0;
            gap_cnt <= 8'd0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        gap_cnt_nxt = gap_cnt;
        data_nxt    = 8'h00;
        valid_nxt   = 1'b0;
        sync_nxt    = 1'b0;
        lfsr_step   = 1'b0;
        case (state)
            S_IDLE: begin
                if (EN) begin
                    state_nxt = S_HDR;
                    idx_nxt   = 8'd0;
                end
            end
            S_HDR: begin
                valid_nxt = 1'b1;
                idx_nxt   = idx + 8'd1;
                case (idx[1:0])
                    2'd0: begin
                        data_nxt = 8'h47;
                        sync_nxt = 1'b1;
                    end
                    2'd1: data_nxt = {3'b000, pid[12:8]};
                    2'd2: data_nxt = pid[7:0];
                    default: begin
                        data_nxt  = {4'h1, cc[slot]};
                        state_nxt = S_PAY;
                    end
                endcase
            end
            S_PAY: begin
                valid_nxt = 1'b1;
                idx_nxt   = idx + 8'd1;
                case (mode_lat)
                    2'd0: data_nxt = pid[7:0];
                    2'd1: data_nxt = idx - 8'd4;
                    2'd2: begin
                        data_nxt  = lfsr[7:0];
                        lfsr_step = 1'b1;
                    end
                    default: data_nxt = 8'hFF;
                endcase
                if (idx == LAST_IDX) begin
                    state_nxt   = after_pkt;
                    idx_nxt     = 8'd0;
                    gap_cnt_nxt = 8'd0;
                end else if (idx == 8'd187) begin
                    state_nxt = S_PAR;
                end
            end
            S_PAR: begin
                idx_nxt = idx + 8'd1;
                if (idx == LAST_IDX) begin
                    state_nxt   = after_pkt;
                    idx_nxt     = 8'd0;
                    gap_cnt_nxt = 8'd0;
                end
            end
            S_GAP: begin
                gap_cnt_nxt = gap_cnt + 8'd1;
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = EN ? S_HDR : S_IDLE;
                    idx_nxt   = 8'd0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // output register stage; packet bookkeeping trails the last byte by one cycle
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            DATA     <= 8'h00;
            D_VALID  <= 1'b0;
            P_SYNC   <= 1'b0;
            PKT_CNT  <= 16'd0;
            slot     <= 3'd0;
            lfsr     <= 15'h7FFF;
            base_lat <= 13'd0;
            mode_lat <= 2'd0;
            done_p1  <= 1'b0;
            for (int i = 0; i < 8; i++) cc[i] <= 4'h0;
        end else begin
            DATA    <= data_nxt;
            D_VALID <= valid_nxt;
            P_SYNC  <= sync_nxt;
            done_p1 <= pkt_end;
            if ((state == S_HDR) && (idx == 8'd0)) begin
                base_lat <= PID_BASE;
                mode_lat <= MODE;
            end
            if (lfsr_step) lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
            if (done_p1) begin
                PKT_CNT  <= PKT_CNT + 16'd1;
                cc[slot] <= cc[slot] + 4'd1;
                slot     <= (slot == SLOT_LAST) ? 3'd0 : slot + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_ts_pattern_gen.sv
// Scoreboard bench for ts_pattern_gen: a default 188-byte/4-PID instance and a
// 204-byte/1-PID/3-gap instance share clock and reset.
module tb_ts_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en_a, en_b;
    logic [12:0] base_a, base_b;
    logic [1:0]  mode_a, mode_b;
    logic [7:0]  data_a, data_b;
    logic        dclk_a, dclk_b, vld_a, vld_b, sync_a, sync_b;
    logic [15:0] cnt_a, cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    int          m_slot [2];
    logic [3:0]  m_cc   [2][8];
    logic [14:0] m_lfsr [2];
    int          n_pid  [2];

    ts_pattern_gen u_a (
        .CLK(clk), .RST(rst_n), .EN(en_a), .PID_BASE(base_a), .MODE(mode_a),
        .DATA(data_a), .D_CLK(dclk_a), .D_VALID(vld_a), .P_SYNC(sync_a), .PKT_CNT(cnt_a)
    );

    ts_pattern_gen #(.PKT_LEN(204), .N_PID(1), .GAP(3)) u_b (
        .CLK(clk), .RST(rst_n), .EN(en_b), .PID_BASE(base_b), .MODE(mode_b),
        .DATA(data_b), .D_CLK(dclk_b), .D_VALID(vld_b), .P_SYNC(sync_b), .PKT_CNT(cnt_b)
    );

    task automatic model_reset;
        for (int d = 0; d < 2; d++) begin
            m_slot[d] = 0;
            m_lfsr[d] = 15'h7FFF;
            for (int k = 0; k < 8; k++) m_cc[d][k] = 4'h0;
        end
        n_pid[0] = 4;
        n_pid[1] = 1;
        qa.delete();
        qb.delete();
    endtask

    // Appends the 188 valid bytes of the next packet of instance d to its queue.
    task automatic push_pkt(input int d, input logic [12:0] base, input logic [1:0] mode);
        logic [12:0] p;
        logic [7:0]  b;
        p = base + 13'(m_slot[d]);
        for (int i = 0; i < 188; i++) begin
            case (i)
                0: b = 8'h47;
                1: b = {3'b000, p[12:8]};
                2: b = p[7:0];
                3: b = {4'h1, m_cc[d][m_slot[d]]};
                default: begin
                    case (mode)
                        2'd0: b = p[7:0];
                        2'd1: b = 8'(i - 4);
                        2'd2: begin
                            b = m_lfsr[d][7:0];
                            m_lfsr[d] = {m_lfsr[d][13:0], m_lfsr[d][14] ^ m_lfsr[d][13]};
                        end
                        default: b = 8'hFF;
                    endcase
                end
            endcase
            if (d == 0) qa.push_back(b);
            else qb.push_back(b);
        end
        m_cc[d][m_slot[d]] = m_cc[d][m_slot[d]] + 4'd1;
        m_slot[d] = (m_slot[d] + 1) % n_pid[d];
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en_a = 1'b0; en_b = 1'b0;
        base_a = 13'd0; base_b = 13'd0;
        mode_a = 2'd0; mode_b = 2'd0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (data_a !== 8'h00) begin n_fail++; $display("FAIL reset_data_a: got %h expected 00", data_a); end
        n_checks++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a: got %b expected 0", vld_a); end
        n_checks++; if (sync_a !== 1'b0) begin n_fail++; $display("FAIL reset_sync_a: got %b expected 0", sync_a); end
        n_checks++; if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL reset_cnt_a: got %h expected 0000", cnt_a); end
        n_checks++; if (data_b !== 8'h00 || vld_b !== 1'b0 || cnt_b !== 16'd0) begin
            n_fail++; $display("FAIL reset_b: got data %h vld %b cnt %h expected 00 0 0000", data_b, vld_b, cnt_b);
        end
        n_checks++; if (dclk_a !== 1'b0 || dclk_b !== 1'b0) begin n_fail++; $display("FAIL dclk_low: got %b %b expected 0", dclk_a, dclk_b); end
        @(posedge clk); #1;
        n_checks++; if (dclk_a !== 1'b1 || dclk_b !== 1'b1) begin n_fail++; $display("FAIL dclk_high: got %b %b expected 1", dclk_a, dclk_b); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (vld_a !== 1'b0 || sync_a !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got vld %b sync %b expected 0 0", vld_a, sync_a); end
    endtask

    task automatic test_round_robin;
        logic [7:0] e;
        int p, i;
        base_a = 13'h100;
        mode_a = 2'd1;
        for (int k = 0; k < 5; k++) push_pkt(0, base_a, mode_a);
        en_a = 1'b1;
        @(negedge clk);
        n_checks++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL start_latency: got vld %b expected 0", vld_a); end
        for (int c = 0; c < 5 * 188; c++) begin
            @(negedge clk);
            p = c / 188;
            i = c % 188;
            n_checks++; if (vld_a !== 1'b1) begin n_fail++; $display("FAIL rr_valid c=%0d: got %b expected 1", c, vld_a); end
            if (qa.size() > 0) e = qa.pop_front(); else e = 8'hxx;
            n_checks++; if (data_a !== e) begin n_fail++; $display("FAIL rr_data p=%0d i=%0d: got %h expected %h", p, i, data_a, e); end
            n_checks++; if (sync_a !== (i == 0)) begin n_fail++; $display("FAIL rr_sync p=%0d i=%0d: got %b", p, i, sync_a); end
            n_checks++; if (cnt_a !== 16'(p)) begin n_fail++; $display("FAIL rr_cnt p=%0d i=%0d: got %0d expected %0d", p, i, cnt_a, p); end
            if (p == 1 && i == 2) begin
                n_checks++; if (data_a !== 8'h01) begin n_fail++; $display("FAIL rr_pid_slot1: got %h expected 01", data_a); end
            end
            if (p == 4 && i == 2) begin
                n_checks++; if (data_a !== 8'h00) begin n_fail++; $display("FAIL rr_pkt5_pid: got %h expected 00", data_a); end
            end
            if (p == 4 && i == 3) begin
                n_checks++; if (data_a !== 8'h11) begin n_fail++; $display("FAIL rr_pkt5_cc: got %h expected 11", data_a); end
            end
        end
    endtask

    task automatic test_en_drop;
        logic [7:0] e;
        push_pkt(0, base_a, mode_a);
        for (int c = 0; c < 188; c++) begin
            @(negedge clk);
            if (qa.size() > 0) e = qa.pop_front(); else e = 8'hxx;
            n_checks++; if (vld_a !== 1'b1 || data_a !== e) begin
                n_fail++; $display("FAIL drop_byte i=%0d: got vld %b data %h expected 1 %h", c, vld_a, data_a, e);
            end
            n_checks++; if (cnt_a !== 16'd5) begin n_fail++; $display("FAIL drop_cnt_during i=%0d: got %0d expected 5", c, cnt_a); end
            if (c == 50) en_a = 1'b0;
        end
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            n_checks++; if (vld_a !== 1'b0 || sync_a !== 1'b0 || data_a !== 8'h00) begin
                n_fail++; $display("FAIL drop_idle c=%0d: got vld %b sync %b data %h expected 0 0 00", c, vld_a, sync_a, data_a);
            end
        end
        n_checks++; if (cnt_a !== 16'd6) begin n_fail++; $display("FAIL drop_cnt_after: got %0d expected 6", cnt_a); end
    endtask

    task automatic test_reset_mid_packet;
        logic [7:0] e;
        bit seen;
        base_a = 13'h0AB;
        mode_a = 2'd3;
        en_a = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            @(negedge clk);
            seen = sync_a;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rst_mid_start: got no sync expected sync within 5 cycles"); end
        repeat (100) @(negedge clk);
        n_checks++; if (vld_a !== 1'b1 || data_a !== 8'hFF || cnt_a !== 16'd6) begin
            n_fail++; $display("FAIL rst_mid_pre: got vld %b data %h cnt %0d expected 1 ff 6", vld_a, data_a, cnt_a);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (vld_a !== 1'b0 || data_a !== 8'h00 || sync_a !== 1'b0 || cnt_a !== 16'd0) begin
            n_fail++; $display("FAIL rst_mid_async: got vld %b data %h sync %b cnt %0d expected 0 00 0 0", vld_a, data_a, sync_a, cnt_a);
        end
        model_reset();
        base_a = 13'h1FFE;
        mode_a = 2'd0;
        push_pkt(0, base_a, mode_a);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL rst_mid_latency: got vld %b expected 0", vld_a); end
        for (int c = 0; c < 188; c++) begin
            @(negedge clk);
            if (qa.size() > 0) e = qa.pop_front(); else e = 8'hxx;
            n_checks++; if (vld_a !== 1'b1 || data_a !== e) begin
                n_fail++; $display("FAIL rst_mid_byte i=%0d: got vld %b data %h expected 1 %h", c, vld_a, data_a, e);
            end
            if (c == 3) begin
                n_checks++; if (data_a !== 8'h10) begin n_fail++; $display("FAIL rst_mid_cc: got %h expected 10", data_a); end
            end
            if (c == 2) begin
                n_checks++; if (data_a !== 8'hFE) begin n_fail++; $display("FAIL rst_mid_pid: got %h expected fe", data_a); end
            end
            n_checks++; if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL rst_mid_cnt i=%0d: got %0d expected 0", c, cnt_a); end
            if (c == 100) en_a = 1'b0;
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_pid_wrap;
        logic [7:0] e;
        logic [7:0] lo_tab [4];
        int p, i;
        lo_tab[0] = 8'hFE; lo_tab[1] = 8'hFF; lo_tab[2] = 8'h00; lo_tab[3] = 8'h01;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        base_a = 13'h1FFE;
        mode_a = 2'd0;
        for (int k = 0; k < 68; k++) push_pkt(0, base_a, mode_a);
        en_a = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 68 * 188; c++) begin
            @(negedge clk);
            p = c / 188;
            i = c % 188;
            if (qa.size() > 0) e = qa.pop_front(); else e = 8'hxx;
            n_checks++; if (vld_a !== 1'b1 || data_a !== e) begin
                n_fail++; $display("FAIL wrap_byte p=%0d i=%0d: got vld %b data %h expected 1 %h", p, i, vld_a, data_a, e);
            end
            n_checks++; if (sync_a !== (i == 0) || cnt_a !== 16'(p)) begin
                n_fail++; $display("FAIL wrap_ctl p=%0d i=%0d: got sync %b cnt %0d expected cnt %0d", p, i, sync_a, cnt_a, p);
            end
            if (p < 4 && i == 1) begin
                n_checks++; if (data_a !== ((p < 2) ? 8'h1F : 8'h00)) begin n_fail++; $display("FAIL wrap_pid_hi p=%0d: got %h", p, data_a); end
            end
            if (p < 4 && (i == 2 || i == 4)) begin
                n_checks++; if (data_a !== lo_tab[p]) begin n_fail++; $display("FAIL wrap_pid_lo p=%0d i=%0d: got %h expected %h", p, i, data_a, lo_tab[p]); end
            end
            if (p >= 60 && p < 64 && i == 3) begin
                n_checks++; if (data_a !== 8'h1F) begin n_fail++; $display("FAIL wrap_cc15 p=%0d: got %h expected 1f", p, data_a); end
            end
            if (p >= 64 && i == 3) begin
                n_checks++; if (data_a !== 8'h10) begin n_fail++; $display("FAIL wrap_cc0 p=%0d: got %h expected 10", p, data_a); end
            end
            if (p == 67 && i == 10) en_a = 1'b0;
        end
        repeat (200) @(negedge clk);
        n_checks++; if (vld_a !== 1'b0 || qa.size() != 0) begin
            n_fail++; $display("FAIL wrap_end: got vld %b queue %0d expected 0 0", vld_a, qa.size());
        end
    endtask

    task automatic test_prbs_par_gap;
        logic [7:0] e;
        int p, i, last_sync;
        base_b = 13'h0055;
        mode_b = 2'd2;
        for (int k = 0; k < 3; k++) push_pkt(1, base_b, mode_b);
        last_sync = -1;
        en_b = 1'b1;
        @(negedge clk);
        n_checks++; if (vld_b !== 1'b0) begin n_fail++; $display("FAIL b_latency: got vld %b expected 0", vld_b); end
        for (int c = 0; c < 3 * 207; c++) begin
            @(negedge clk);
            p = c / 207;
            i = c % 207;
            if (i < 188) begin
                if (qb.size() > 0) e = qb.pop_front(); else e = 8'hxx;
                n_checks++; if (vld_b !== 1'b1 || data_b !== e) begin
                    n_fail++; $display("FAIL b_byte p=%0d i=%0d: got vld %b data %h expected 1 %h", p, i, vld_b, data_b, e);
                end
                if (i == 3) begin
                    n_checks++; if (data_b !== 8'(8'h10 + p)) begin n_fail++; $display("FAIL b_cc p=%0d: got %h expected %h", p, data_b, 8'(8'h10 + p)); end
                end
                if (p == 0 && (i == 4 || i == 5)) begin
                    n_checks++; if (data_b !== ((i == 4) ? 8'hFF : 8'hFE)) begin n_fail++; $display("FAIL b_prbs_first i=%0d: got %h", i, data_b); end
                end
            end else begin
                n_checks++; if (vld_b !== 1'b0 || data_b !== 8'h00) begin
                    n_fail++; $display("FAIL b_par_gap p=%0d i=%0d: got vld %b data %h expected 0 00", p, i, vld_b, data_b);
                end
            end
            n_checks++; if (sync_b !== (i == 0)) begin n_fail++; $display("FAIL b_sync p=%0d i=%0d: got %b", p, i, sync_b); end
            if (sync_b === 1'b1) begin
                if (last_sync >= 0) begin
                    n_checks++; if (c - last_sync != 207) begin n_fail++; $display("FAIL b_period: got %0d expected 207", c - last_sync); end
                end
                last_sync = c;
            end
            n_checks++; if (cnt_b !== 16'((i >= 204) ? p + 1 : p)) begin
                n_fail++; $display("FAIL b_cnt p=%0d i=%0d: got %0d expected %0d", p, i, cnt_b, (i >= 204) ? p + 1 : p);
            end
            if (p == 2 && i == 10) en_b = 1'b0;
        end
        repeat (20) @(negedge clk);
        n_checks++; if (vld_b !== 1'b0 || sync_b !== 1'b0 || cnt_b !== 16'd3) begin
            n_fail++; $display("FAIL b_end: got vld %b sync %b cnt %0d expected 0 0 3", vld_b, sync_b, cnt_b);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_en_drop();
        test_reset_mid_packet();
        test_pid_wrap();
        test_prbs_par_gap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ts_pattern_gen.md
TS_PATTERN_GEN -- requirements
Module: ts_pattern_gen

Interface
REQ-001 SHALL have parameter PKT_LEN, default 188, legal values 188 or 204: output packet length in bytes.
REQ-002 SHALL have parameter N_PID, default 4, legal values 1..8: number of PIDs rotated round-robin.
REQ-003 SHALL have parameter GAP, default 0, legal values 0..255: idle cycles inserted after every packet.
REQ-004 SHALL have port CLK, input, width 1: the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port RST, input, width 1: asynchronous, active-low reset.
REQ-006 SHALL have port EN, input, width 1: generation enable, sampled only at packet start.
REQ-007 SHALL have port PID_BASE, input, width 13: PID of rotation slot 0.
REQ-008 SHALL have port MODE, input, width 2: payload mode. 0 = constant PID[7:0]; 1 = incrementing byte; 2 = PRBS-15; 3 = 0xFF.
REQ-009 SHALL have port DATA, output, width 8: TS byte, registered.
REQ-010 SHALL have port D_CLK, output, width 1: equal to CLK.
REQ-011 SHALL have port D_VALID, output, width 1: DATA is a packet byte, registered.
REQ-012 SHALL have port P_SYNC, output, width 1: high with byte 0 of each packet, registered.
REQ-013 SHALL have port PKT_CNT, output, width 16: count of completed packets; wraps from 0xFFFF to 0.

Function
REQ-014 SHALL run the FSM states IDLE, HDR, PAY, PAR and GAP.
- IDLE -> HDR when EN=1.
- HDR covers bytes 0..3. PAY covers bytes 4..187.
- PAR covers bytes 188..203 and is entered only when PKT_LEN=204.
- GAP lasts GAP cycles and is skipped when GAP=0.
- After the last packet byte or GAP: go to HDR if EN=1, else IDLE.
REQ-015 SHALL emit the first byte (0x47) on the edge after the first rising edge where the FSM is in IDLE and sees EN=1; this is 1 cycle of latency.
REQ-016 SHALL form headers from the current slot PID P = (PID_BASE + slot) mod 8192, with no saturation:
- byte0 = 0x47;
- byte1 = {3'b000, P[12:8]};
- byte2 = P[7:0];
- byte3 = 0x10 | CC[slot].
REQ-017 SHALL keep a separate 4-bit continuity counter CC[slot] for each slot, start it at 0, and increment it (wrapping 15 -> 0) after each packet of that slot.
REQ-018 SHALL advance the slot 0 -> 1 -> ... -> N_PID-1 -> 0 after each packet; with N_PID=1 the slot is always 0.
REQ-019 SHALL latch MODE and PID_BASE at byte 0; changes mid-packet SHALL take effect from the next packet.
REQ-020 SHALL generate payload bytes as follows:
- mode 1: the byte is (byte index - 4) mod 256, so byte4 = 0x00.
- mode 2: a PRBS-15 LFSR with seed 0x7FFF at reset; DATA = lfsr[7:0]; then lfsr <= {lfsr[13:0], lfsr[14]^lfsr[13]}, one shift per payload byte; the LFSR is never reseeded between packets.
REQ-021 SHALL drive D_VALID=1 in HDR and PAY, and D_VALID=0 in PAR, GAP and IDLE.
REQ-022 SHALL drive DATA=0x00 in PAR, GAP and IDLE.
REQ-023 SHALL drive P_SYNC=1 only in the cycle DATA=0x47 at byte 0.
REQ-024 SHALL always complete a packet that has started, even if EN falls mid-packet; PAR and GAP SHALL also complete before the FSM enters IDLE.
REQ-025 SHALL increment PKT_CNT in the cycle after the last byte of the packet, which is the last PAY or PAR byte.
REQ-026 SHALL advance CC and slot at the same edge as PKT_CNT.

Reset
REQ-027 SHALL set the following while RST=0, regardless of clock:
- DATA=0x00, D_VALID=0, P_SYNC=0, PKT_CNT=0;
- FSM=IDLE, all CC=0, slot=0, lfsr=0x7FFF.
REQ-028 SHALL abandon any partial packet when reset is asserted mid-packet; after release the next packet restarts at slot 0 with CC=0.

Verification
REQ-029 SHALL be covered by scenario V1: defaults, PID_BASE=0x100, MODE=1, EN=1 -> packets every 188 cycles, D_VALID continuously 1, slot PIDs 0x100..0x103 repeating, packet 5 has PID 0x100 with byte3=0x11.
REQ-030 SHALL be covered by scenario V2: PKT_LEN=204, GAP=3 -> 188 valid bytes, then 16 cycles with D_VALID=0 and DATA=0, then 3 gap cycles; P_SYNC period is 207 cycles.
REQ-031 SHALL be covered by scenario V3: MODE=2, N_PID=1 -> first payload byte 0xFF; payload matches a reference PRBS-15 model from seed 0x7FFF across 3 packets without reseeding.
REQ-032 SHALL be covered by scenario V4: EN dropped at byte 50 -> the packet completes to byte 187, then IDLE; PKT_CNT increments by 1 and no further P_SYNC appears.
REQ-033 SHALL be covered by scenario V5: PID_BASE=0x1FFE, N_PID=4 -> PIDs 0x1FFE, 0x1FFF, 0x0000, 0x0001; CC wraps 15 -> 0 on the 17th packet of each PID.
REQ-034 SHALL be covered by scenario V6: RST pulsed at byte 100 -> outputs are 0 asynchronously; after release the first packet has PID=PID_BASE, byte3=0x10 and PKT_CNT=0.
